// File: rtl/mqnic_rx_queue_map_if.sv
// AXI-stream bundle used by the RX queue mapper on both its ingress and egress sides.
// tdest is only meaningful on the egress side.
interface mqnic_rx_queue_map_if #(
  parameter int unsigned DataWidth = 256,
  parameter int unsigned KeepWidth = DataWidth / 8,
  parameter int unsigned IdWidth   = 8,
  parameter int unsigned UserWidth = 45,
  parameter int unsigned DestWidth = 8
);
  logic [DataWidth-1:0] tdata;
  logic [KeepWidth-1:0] tkeep;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic [IdWidth-1:0]   tid;
  logic [UserWidth-1:0] tuser;
  logic [DestWidth-1:0] tdest;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tuser, tdest, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tuser, tdest, output tready);
endinterface

// File: rtl/mqnic_rx_queue_map.sv
// Per-packet RX queue selection: tdest = base[func] + (hash & mask[func]), with whole-packet
// drop for unknown or disabled functions. One registered output stage, full throughput.
module mqnic_rx_queue_map #(
  parameter int unsigned AXIS_DATA_WIDTH      = 256,
  parameter int unsigned AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_ID_WIDTH        = 8,
  parameter int unsigned USER_WIDTH           = 1,
  parameter int unsigned AXIS_USER_WIDTH      = USER_WIDTH + 44,
  parameter int unsigned RX_QUEUE_INDEX_WIDTH = 8,
  parameter int unsigned FUNC_COUNT           = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  mqnic_rx_queue_map_if.slave             s_axis,
  mqnic_rx_queue_map_if.master            m_axis,
  input  logic                            cfg_wr_en_i,
  input  logic [7:0]                      cfg_wr_func_i,
  input  logic [RX_QUEUE_INDEX_WIDTH-1:0] cfg_wr_base_i,
  input  logic [RX_QUEUE_INDEX_WIDTH-1:0] cfg_wr_mask_i,
  input  logic                            cfg_wr_enable_i,
  output logic                            stat_drop_o,
  output logic [31:0]                     stat_drop_count_o
);
  localparam int unsigned QW = RX_QUEUE_INDEX_WIDTH;

  typedef enum logic [1:0] {StSop, StPass, StDrop} state_e;

  state_e                     state_q;
  logic [QW-1:0]              base_q [FUNC_COUNT];
  logic [QW-1:0]              mask_q [FUNC_COUNT];
  logic                       en_q   [FUNC_COUNT];
  logic [QW-1:0]              dest_pkt_q;
  logic                       valid_q;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q;
  logic [AXIS_KEEP_WIDTH-1:0] tkeep_q;
  logic                       tlast_q;
  logic [AXIS_ID_WIDTH-1:0]   tid_q;
  logic [AXIS_USER_WIDTH-1:0] tuser_q;
  logic [QW-1:0]              tdest_q;
  logic                       drop_q;
  logic [31:0]                drop_cnt_q;

  logic [7:0]    func_id;
  logic [QW-1:0] hash_lo;
  logic [QW-1:0] lut_base;
  logic [QW-1:0] lut_mask;
  logic [QW-1:0] lut_dest;
  logic          lut_ok;
  logic          s_ready;
  logic          s_hs;
  logic          fwd;

  assign func_id = s_axis.tuser[AXIS_USER_WIDTH-1 -: 8];
  assign hash_lo = s_axis.tuser[USER_WIDTH +: QW];

  // Out-of-range function ids match no entry and therefore read as invalid.
  always_comb begin
    lut_ok   = 1'b0;
    lut_base = '0;
    lut_mask = '0;
    for (int i = 0; i < FUNC_COUNT; i++) begin
      if (func_id == 8'(i)) begin
        lut_ok   = en_q[i];
        lut_base = base_q[i];
        lut_mask = mask_q[i];
      end
    end
  end

  assign lut_dest = lut_base + (hash_lo & lut_mask);
  assign s_ready  = (state_q == StDrop) | m_axis.tready | ~valid_q;
  assign s_hs     = s_axis.tvalid & s_ready;
  assign fwd      = s_hs & (((state_q == StSop) & lut_ok) | (state_q == StPass));

  assign s_axis.tready     = s_ready;
  assign m_axis.tvalid     = valid_q;
  assign m_axis.tdata      = tdata_q;
  assign m_axis.tkeep      = tkeep_q;
  assign m_axis.tlast      = tlast_q;
  assign m_axis.tid        = tid_q;
  assign m_axis.tuser      = tuser_q;
  assign m_axis.tdest      = tdest_q;
  assign stat_drop_o       = drop_q;
  assign stat_drop_count_o = drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FUNC_COUNT; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= '0;
        en_q[i]   <= 1'b1;
      end
    end else if (cfg_wr_en_i) begin
      for (int i = 0; i < FUNC_COUNT; i++) begin
        if (cfg_wr_func_i == 8'(i)) begin
          base_q[i] <= cfg_wr_base_i;
          mask_q[i] <= cfg_wr_mask_i;
          en_q[i]   <= cfg_wr_enable_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSop;
      dest_pkt_q <= '0;
      valid_q    <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tid_q      <= '0;
      tuser_q    <= '0;
      tdest_q    <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q <= 1'b0;
      if (m_axis.tready) valid_q <= 1'b0;
      // fwd implies the output register is free or being consumed this cycle.
      if (fwd) begin
        valid_q <= 1'b1;
        tdata_q <= s_axis.tdata;
        tkeep_q <= s_axis.tkeep;
        tlast_q <= s_axis.tlast;
        tid_q   <= s_axis.tid;
        tuser_q <= s_axis.tuser;
        tdest_q <= (state_q == StSop) ? lut_dest : dest_pkt_q;
      end
      if (s_hs) begin
        unique case (state_q)
          StSop: begin
            if (lut_ok) begin
              dest_pkt_q <= lut_dest;
              state_q    <= s_axis.tlast ? StSop : StPass;
            end else begin
              drop_q  <= 1'b1;
              if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
              state_q <= s_axis.tlast ? StSop : StDrop;
            end
          end
          StPass, StDrop: begin
            if (s_axis.tlast) state_q <= StSop;
          end
          default: state_q <= StSop;
        endcase
      end
    end
  end
endmodule

// File: doc/mqnic_rx_queue_map.md
Name: mqnic_rx_queue_map

Overview:
- Stage directly downstream of the NIC ingress block.
- Consumes the ingress RX stream, whose tuser carries {function_id[7:0], hash_type[3:0], hash[31:0], user}, and selects a receive queue per packet.
- Queue = base[function_id] + (hash & mask[function_id]), taken from a per-function table.
- Emits the packet unchanged with tdest = queue index, or drops the whole packet when its function is invalid or disabled.

Parameters:
- AXIS_DATA_WIDTH, 256, stream data width.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- AXIS_ID_WIDTH, 8, tid width.
- USER_WIDTH, 1, width of the original (pre-hash) user field.
- AXIS_USER_WIDTH, USER_WIDTH+44, full tuser width: {function_id, hash_type, hash, user}.
- RX_QUEUE_INDEX_WIDTH, 8, queue index width; also the output tdest width.
- FUNC_COUNT, 4, number of table entries, 1..256.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  AXIS_DATA_WIDTH  input data
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  input keep
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input last
- s_axis_tid  in  AXIS_ID_WIDTH  input id
- s_axis_tuser  in  AXIS_USER_WIDTH  input user: function_id [MSB-:8], hash_type next 4, hash next 32, user in [USER_WIDTH-1:0]
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tuser  out (tready in)  same widths as the input side  output stream
- m_axis_tdest  out  RX_QUEUE_INDEX_WIDTH  selected queue
- cfg_wr_en  in  1  table write strobe
- cfg_wr_func  in  8  entry index to write
- cfg_wr_base  in  RX_QUEUE_INDEX_WIDTH  base queue value
- cfg_wr_mask  in  RX_QUEUE_INDEX_WIDTH  hash mask value
- cfg_wr_enable  in  1  entry enable
- stat_drop  out  1  one-cycle pulse per dropped packet
- stat_drop_count  out  32  saturating count of dropped packets

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-release usage):
  - m_axis_tvalid=0, stat_drop=0, stat_drop_count=0, state=SOP.
  - All table entries: base=0, mask=0, enable=1.
  - Data, tdest and user registers: don't-care; reset them to 0.
- Output stage:
  - Single registered stage; latency 1 cycle from input handshake to m_axis_tvalid.
  - s_axis_tready = (m_axis_tready | ~m_axis_tvalid) in SOP and PASS; s_axis_tready = 1 in DROP.
  - No bubbles at full throughput.
- State machine:
  - SOP, on a first-beat handshake:
    - Look up the entry for function_id.
    - Valid when function_id < FUNC_COUNT and enable=1.
    - Valid: register the beat with tdest = (base + (hash[RX_QUEUE_INDEX_WIDTH-1:0] & mask)) mod 2^RX_QUEUE_INDEX_WIDTH; hold tdest in a packet register. Go to PASS, or stay in SOP if tlast.
    - Invalid: discard the beat, go to DROP, or stay in SOP with a drop if tlast.
  - PASS: forward each beat with the held tdest; tlast handshake -> SOP.
  - DROP: accept and discard every beat; tlast handshake -> SOP.
- Drops:
  - stat_drop pulses in the cycle after the first-beat handshake of a dropped packet.
  - stat_drop_count increments at the same time and saturates at 0xFFFFFFFF.
- Pass-through fields: tdata, tkeep, tlast, tid and the full tuser pass unmodified.
- Table:
  - Written synchronously when cfg_wr_en=1; writes with cfg_wr_func >= FUNC_COUNT are ignored.
  - Entry values are sampled only at SOP, so a write during a packet affects only later packets.
  - Write and lookup of the same entry in the same cycle: the lookup sees the old value.
- Backpressure: m_axis_tready low holds all m_axis outputs stable; tvalid is never retracted once asserted until the handshake.
- Reset mid-packet: state returns to SOP and the partial output is lost. The next input beat is treated as a first beat.

Test Plan:
- Reset, then a 3-beat packet with function_id=0, hash=0x12345678 -> output on the next cycle with tdest=0 on all 3 beats, data identical, tuser unchanged.
- cfg write func=1 base=0x10 mask=0x0F; packet with function_id=1, hash=0xABCD00F7 -> tdest=0x17.
- Wrap: cfg func=2 base=0xF8 mask=0xFF; hash=0x0C -> tdest=0x04.
- cfg func=3 enable=0; send a 4-beat packet with function_id=3, then a packet with function_id=5 -> no output beats, s_axis_tready=1 throughout, stat_drop pulses twice, stat_drop_count=2.
- Random m_axis_tready at 30% duty with back-to-back single-beat and multi-beat packets -> output matches a scoreboard, no beat loss or duplication, tvalid stable under backpressure.
- Write func=1 base=0x20 during beat 2 of a func=1 packet -> the current packet keeps tdest=0x17 (hash low bits 0xF7 with mask 0x0F), the next packet uses base 0x20.
